philv_trace_tx: RTL and testbench
=================================

# philv_trace_tx

Hardware trace transmitter for the Philosophy V core. Each enabled cycle it snapshots the core's controller state, IF-stage PC, fetched instruction and write-back value, and queues the snapshot as a fixed 14-byte record. Records are streamed out over a byte-wide valid/ready interface to a UART bridge or host capture FIFO. This puts per-cycle core visibility on silicon/FPGA, not only in simulation.

## Interface
- DEPTH, 4: record FIFO depth in records; power of two, 2..16.
- clk  in  1  core clock; all logic rising-edge.
- rstb  in  1  synchronous, active-low reset.
- trace_en  in  1  capture enable; sampled every rising edge.
- core_state  in  4  main-controller state.
- core_pc  in  32  IF-stage PC register value.
- core_instr  in  32  instruction-memory read data.
- core_wb  in  32  WB pipeline register value.
- tx_data  out  8  current record byte.
- tx_valid  out  1  tx_data is valid.
- tx_ready  in  1  sink accepts the byte when tx_valid && tx_ready.
- tx_last  out  1  high with byte 13 (final byte) of a record.
- drop_cnt  out  8  records lost to overflow; saturates at 255.
- fifo_full  out  1  FIFO holds DEPTH records.

## Operation
- Capture: on each rising edge with rstb=1 and trace_en=1, the record is formed from the input values at that edge and pushed if space exists.
- Record layout, in byte order: 0 = 0xA5 sync; 1 = {ovf, 3'b000, core_state}; 2-5 = core_pc, MSB first; 6-9 = core_instr, MSB first; 10-13 = core_wb, MSB first.
- ovf is bit 7 of byte 1. It is set if at least one record was dropped since the last successful push. A successful push clears the sticky flag.
- Overflow: a capture while full and not popping this cycle is discarded. drop_cnt increments, saturating at 255, and the sticky ovf flag is set.
- Simultaneous push and pop: a pop occurs on the edge where byte 13 is accepted. A capture on that same edge while full is accepted, not dropped.
- Serializer:
  - tx_valid = FIFO not empty.
  - tx_data = byte[idx] of the head record, with idx a 4-bit counter 0..13.
  - Each accepted byte advances idx.
  - Acceptance at idx=13 pops the head and wraps idx to 0.
- No per-record FSM beyond idx; the streaming state is {EMPTY, SENDING(idx)}.
- FIFO: read and write pointers are log2(DEPTH)+1 bits wide. Full is when the MSBs differ and the lower bits are equal; empty is when the pointers are equal.

## Timing
- Reset, rstb low at a rising edge:
  - At the next edge: tx_valid=0, tx_last=0, tx_data=0x00, drop_cnt=0, fifo_full=0.
  - Pointers, idx and ovf are cleared.
  - Captures are ignored during reset.
- Reset mid-record: the partial record is abandoned. The stream resumes after reset only on a fresh record starting with 0xA5.
- Latency: a capture at edge N into an empty FIFO gives tx_valid=1 with tx_data=0xA5 after edge N; the first byte can be accepted at edge N+1.
- Throughput: one byte per cycle when tx_ready is held high, so 14 cycles per record.
- Sustained trace_en=1 overflows the FIFO; dropping is expected.
- Stability: while tx_valid && !tx_ready, tx_data and tx_last hold their values. tx_valid never deasserts without an acceptance, except on reset.
- fifo_full and drop_cnt update on the same edge as the push/pop that changes them.

## Test plan
- Single record: reset, then one capture with state=3, pc=0x00000010, instr=0x00500113, wb=0x00000005, tx_ready=1.
  - Expect bytes A5 03 00 00 00 10 00 50 01 13 00 00 00 05.
  - tx_last only on the 14th byte; tx_valid=0 afterwards.
- Backpressure: as above with tx_ready toggling 1,0,0,1,... -> identical byte sequence; tx_data stable during every stall cycle.
- Overflow, DEPTH=4, tx_ready=0: 7 consecutive captures -> fifo_full=1 after the 4th and drop_cnt=3.
  - Release tx_ready: exactly 4 records emerge.
  - A new capture afterwards has byte1 bit7=1; the next one has bit7=0.
- Push on pop: FIFO full with tx_ready=1, and a capture on the edge where byte 13 is accepted -> record kept, drop_cnt unchanged, fifo_full remains 1.
- Saturation: 300 dropped captures -> drop_cnt=255 and it holds.
- Reset mid-record: rstb=0 at byte 6 -> tx_valid=0, drop_cnt=0 after the edge.
  - Next capture after release: stream restarts at 0xA5 with idx 0.

Source files
------------

// File: rtl/philv_trace_tx.sv
// Per-cycle trace capture for the Philosophy V core: snapshots are queued as
// 14-byte records and streamed out one byte per accepted handshake.
module philv_trace_tx #(
   parameter int unsigned DEPTH = 4
) (
   input  logic        clk,
   input  logic        rstb,
   input  logic        trace_en,
   input  logic [3:0]  core_state,
   input  logic [31:0] core_pc,
   input  logic [31:0] core_instr,
   input  logic [31:0] core_wb,
   output logic [7:0]  tx_data,
   output logic        tx_valid,
   input  logic        tx_ready,
   output logic        tx_last,
   output logic [7:0]  drop_cnt,
   output logic        fifo_full
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

   // Stored record omits the constant sync byte: {byte1, pc, instr, wb}.
   typedef logic [103:0] rec_t;

   rec_t        mem_q [DEPTH];
   rec_t        head;
   logic [AW:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [3:0]  idx_q, idx_d;
   logic        ovf_q, ovf_d;
   logic [7:0]  drop_q, drop_d;
   logic        empty, full, accept, pop, push, drop;

   always_comb begin
      empty  = (wr_ptr_q == rd_ptr_q);
      full   = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
      accept = !empty && tx_ready;
      pop    = accept && (idx_q == 4'd13);
      // A pop on this edge frees a slot, so a capture while full still fits.
      push   = trace_en && (!full || pop);
      drop   = trace_en && full && !pop;

      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      idx_d    = idx_q;
      ovf_d    = ovf_q;
      drop_d   = drop_q;

      if (accept) begin
         idx_d = pop ? 4'd0 : idx_q + 4'd1;
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PtrOne;
      end
      if (push) begin
         wr_ptr_d = wr_ptr_q + PtrOne;
         ovf_d    = 1'b0;
      end
      if (drop) begin
         ovf_d = 1'b1;
         if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rstb) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         idx_q    <= 4'd0;
         ovf_q    <= 1'b0;
         drop_q   <= 8'd0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         idx_q    <= idx_d;
         ovf_q    <= ovf_d;
         drop_q   <= drop_d;
      end
   end

   always_ff @(posedge clk) begin
      if (rstb && push) begin
         mem_q[wr_ptr_q[AW-1:0]] <= {ovf_q, 3'b000, core_state, core_pc, core_instr, core_wb};
      end
   end

   always_comb begin
      head     = mem_q[rd_ptr_q[AW-1:0]];
      tx_valid = !empty;
      tx_last  = !empty && (idx_q == 4'd13);
      tx_data  = 8'h00;
      if (!empty) begin
         case (idx_q)
            4'd0:    tx_data = 8'hA5;
            4'd1:    tx_data = head[103:96];
            4'd2:    tx_data = head[95:88];
            4'd3:    tx_data = head[87:80];
            4'd4:    tx_data = head[79:72];
            4'd5:    tx_data = head[71:64];
            4'd6:    tx_data = head[63:56];
            4'd7:    tx_data = head[55:48];
            4'd8:    tx_data = head[47:40];
            4'd9:    tx_data = head[39:32];
            4'd10:   tx_data = head[31:24];
            4'd11:   tx_data = head[23:16];
            4'd12:   tx_data = head[15:8];
            4'd13:   tx_data = head[7:0];
            default: tx_data = 8'h00;
         endcase
      end
      drop_cnt  = drop_q;
      fifo_full = full;
   end

endmodule

// File: tb/tb_philv_trace_tx.sv
// Bench for philv_trace_tx: byte scoreboard fed at capture time, checked each
// cycle against the stream, plus directed overflow/push-on-pop/reset sequences.
module tb_philv_trace_tx;

   localparam int unsigned DEPTH = 4;

   logic        clk = 1'b0;
   logic        rstb;
   logic        trace_en;
   logic [3:0]  core_state;
   logic [31:0] core_pc, core_instr, core_wb;
   logic [7:0]  tx_data;
   logic        tx_valid, tx_ready, tx_last;
   logic [7:0]  drop_cnt;
   logic        fifo_full;

   philv_trace_tx #(.DEPTH(DEPTH)) dut (
      .clk        (clk),
      .rstb       (rstb),
      .trace_en   (trace_en),
      .core_state (core_state),
      .core_pc    (core_pc),
      .core_instr (core_instr),
      .core_wb    (core_wb),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .tx_last    (tx_last),
      .drop_cnt   (drop_cnt),
      .fifo_full  (fifo_full)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] d;
      logic       last;
   } sb_t;

   typedef struct {
      logic [3:0]   st;
      logic [31:0]  pc;
      logic [31:0]  instr;
      logic [31:0]  wb;
      bit           bp;
      logic [111:0] exp;
   } vec_t;

   sb_t          sbq[$];
   int           checks = 0;
   int           errors = 0;
   int           records_out = 0;
   logic [7:0]   m_drop = 8'd0;
   bit           m_ovf = 1'b0;
   bit           ext_use = 1'b0;
   logic [111:0] ext_rec;
   vec_t         vecs[4];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic push_rec();
      logic [111:0] r;
      r = ext_use ? ext_rec : {8'hA5, m_ovf, 3'b000, core_state, core_pc, core_instr, core_wb};
      for (int k = 0; k < 14; k++) begin
         sbq.push_back('{d: r[8*(13-k) +: 8], last: (k == 13)});
      end
      m_ovf = 1'b0;
   endtask

   // One clock: compare outputs mid-cycle, advance the model, then take the edge.
   task automatic step();
      int unsigned cnt;
      bit          popped;
      @(negedge clk);
      cnt = (sbq.size() + 13) / 14;
      chk("tx_valid", {31'd0, tx_valid}, {31'd0, sbq.size() != 0});
      chk("fifo_full", {31'd0, fifo_full}, {31'd0, cnt == DEPTH});
      chk("drop_cnt", {24'd0, drop_cnt}, {24'd0, m_drop});
      popped = 1'b0;
      if (sbq.size() != 0) begin
         chk("tx_data", {24'd0, tx_data}, {24'd0, sbq[0].d});
         chk("tx_last", {31'd0, tx_last}, {31'd0, sbq[0].last});
         if (tx_ready) begin
            popped = sbq[0].last;
            if (popped) records_out++;
            void'(sbq.pop_front());
         end
      end
      if (!rstb) begin
         sbq.delete();
         m_drop = 8'd0;
         m_ovf  = 1'b0;
      end else if (trace_en) begin
         if (cnt < DEPTH || popped) begin
            push_rec();
         end else begin
            if (m_drop != 8'hFF) m_drop = m_drop + 8'd1;
            m_ovf = 1'b1;
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input bit bp);
      int n;
      n = 0;
      trace_en = 1'b0;
      while (sbq.size() != 0 && n < 400) begin
         tx_ready = bp ? (n % 3 == 0) : 1'b1;
         step();
         n++;
      end
      if (sbq.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout actual=%0d bytes left required=0", sbq.size());
         sbq.delete();
      end
      tx_ready = 1'b1;
      step();
   endtask

   task automatic capture(input logic [3:0] st, input logic [31:0] pc);
      core_state = st;
      core_pc    = pc;
      core_instr = $urandom;
      core_wb    = $urandom;
      trace_en   = 1'b1;
      step();
      trace_en   = 1'b0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL global_timeout actual=running required=finished");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0] = '{4'h3, 32'h0000_0010, 32'h0050_0113, 32'h0000_0005, 1'b0,
                  112'hA5_03_00000010_00500113_00000005};
      vecs[1] = '{4'hF, 32'hFFFF_FFFC, 32'hDEAD_BEEF, 32'h1234_5678, 1'b1,
                  112'hA5_0F_FFFFFFFC_DEADBEEF_12345678};
      vecs[2] = '{4'h0, 32'h0, 32'h0, 32'h0, 1'b1,
                  112'hA5_00_00000000_00000000_00000000};
      vecs[3] = '{4'hA, 32'h8000_0000, 32'h0000_006F, 32'hFFFF_FFFF, 1'b0,
                  112'hA5_0A_80000000_0000006F_FFFFFFFF};

      rstb = 1'b0; trace_en = 1'b0; tx_ready = 1'b0;
      core_state = 4'd0; core_pc = '0; core_instr = '0; core_wb = '0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, tx_valid}, 32'd0);
      chk("rst_last", {31'd0, tx_last}, 32'd0);
      chk("rst_data", {24'd0, tx_data}, 32'd0);
      chk("rst_drop", {24'd0, drop_cnt}, 32'd0);
      chk("rst_full", {31'd0, fifo_full}, 32'd0);
      rstb = 1'b1;

      // Table-driven single records, some drained under 1,0,0 backpressure.
      for (int i = 0; i < 4; i++) begin
         core_state = vecs[i].st; core_pc = vecs[i].pc;
         core_instr = vecs[i].instr; core_wb = vecs[i].wb;
         ext_rec = vecs[i].exp; ext_use = 1'b1;
         tx_ready = 1'b1; trace_en = 1'b1;
         step();
         trace_en = 1'b0; ext_use = 1'b0;
         drain(vecs[i].bp);
      end

      // Overflow: 7 captures into a stalled 4-deep FIFO.
      tx_ready = 1'b0;
      for (int i = 0; i < 7; i++) capture(4'(i), 32'h1000 + 32'(i));
      step();
      chk("ovf_full", {31'd0, fifo_full}, 32'd1);
      chk("ovf_drop", {24'd0, drop_cnt}, 32'd3);
      records_out = 0;
      drain(1'b0);
      chk("ovf_records", records_out, 32'd4);
      tx_ready = 1'b0;
      capture(4'h1, 32'h2000);
      capture(4'h2, 32'h2004);
      tx_ready = 1'b1;
      step();
      chk("ovf_bit_set", {31'd0, tx_data[7]}, 32'd1);
      repeat (14) step();
      chk("ovf_bit_clr", {31'd0, tx_data[7]}, 32'd0);
      drain(1'b0);

      // Push on pop: capture while full on the edge byte 13 is accepted.
      tx_ready = 1'b0;
      for (int i = 0; i < 4; i++) capture(4'h5, 32'h3000 + 32'(i));
      tx_ready = 1'b1;
      repeat (13) step();
      chk("pp_last", {31'd0, tx_last}, 32'd1);
      capture(4'h6, 32'h3100);
      chk("pp_full", {31'd0, fifo_full}, 32'd1);
      chk("pp_drop", {24'd0, drop_cnt}, 32'd3);
      drain(1'b0);

      // Saturation after a clean reset.
      rstb = 1'b0; step(); rstb = 1'b1;
      tx_ready = 1'b0; trace_en = 1'b1;
      repeat (304) step();
      chk("sat_255", {24'd0, drop_cnt}, 32'd255);
      repeat (5) step();
      chk("sat_hold", {24'd0, drop_cnt}, 32'd255);
      drain(1'b0);

      // Reset while byte 6 is presented; capture during reset is ignored.
      tx_ready = 1'b1;
      capture(4'h7, 32'h4000);
      repeat (6) step();
      rstb = 1'b0; trace_en = 1'b1;
      step();
      rstb = 1'b1; trace_en = 1'b0;
      chk("mid_valid", {31'd0, tx_valid}, 32'd0);
      chk("mid_drop", {24'd0, drop_cnt}, 32'd0);
      chk("mid_data", {24'd0, tx_data}, 32'd0);
      chk("mid_full", {31'd0, fifo_full}, 32'd0);
      step();
      capture(4'h8, 32'h5000);
      chk("mid_restart", {24'd0, tx_data}, 32'hA5);
      drain(1'b1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
